// File: rtl/mii_gen_pkg.sv
// Shared types and character codes for the MII frame generator.
package mii_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_TERM  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE_FIXED = 2'd0,
    MODE_INCR  = 2'd1,
    MODE_PRBS  = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_t;

  localparam logic [7:0]  CODE_IDLE     = 8'h07;
  localparam logic [7:0]  CODE_START    = 8'hFB;
  localparam logic [7:0]  CODE_TERM     = 8'hFD;
  localparam logic [7:0]  CODE_PREAMBLE = 8'h55;
  localparam logic [30:0] PRBS_SEED     = 31'h7FFF_FFFF;

endpackage

// File: rtl/mii_frame_gen_prbs.sv
// Parallel PRBS31 (x^31 + x^28 + 1) stepper: DATA_WIDTH bits per advance, bit 0 generated first.
module prbs31_gen
  import mii_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic                  i_advance,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [30:0] state_r;
  logic [30:0] start_s;
  logic [30:0] next_s;
  logic        fb_s;

  // Loading presents the seed word in the same cycle so the first payload word needs no bubble
  always_comb begin
    if (i_load) begin
      start_s = PRBS_SEED;
    end else begin
      start_s = state_r;
    end
  end

  // Unroll DATA_WIDTH serial shifts; state bit 30 is the oldest bit of the history window
  always_comb begin
    next_s = start_s;
    fb_s   = 1'b0;
    o_data = {DATA_WIDTH{1'b0}};
    for (int k = 0; k < DATA_WIDTH; k++) begin
      fb_s      = next_s[30] ^ next_s[27];
      o_data[k] = fb_s;
      next_s    = {next_s[29:0], fb_s};
    end
  end

  // Generator state register
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= PRBS_SEED;
    end else if (i_advance) begin
      state_r <= next_s;
    end else if (i_load) begin
      state_r <= PRBS_SEED;
    end
  end

endmodule

// File: rtl/mii_frame_gen.sv
// MII/XGMII-style frame generator: idle gap, start+preamble word, payload words, terminate word.
module mii_frame_gen
  import mii_gen_pkg::*;
#(
  parameter int          DATA_WIDTH    = 64,
  localparam int         LANES         = DATA_WIDTH / 8,
  parameter int          LEN_WIDTH     = 16,
  parameter logic [7:0]  IDLE_CODE     = CODE_IDLE,
  parameter logic [7:0]  START_CODE    = CODE_START,
  parameter logic [7:0]  TERM_CODE     = CODE_TERM,
  parameter logic [7:0]  PREAMBLE_CODE = CODE_PREAMBLE
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic [LEN_WIDTH-1:0]  i_idle_len,
  input  logic [LEN_WIDTH-1:0]  i_data_len,
  input  logic [1:0]            i_mode,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic [LANES-1:0]      o_tx_ctrl,
  output logic [31:0]           o_frame_cnt,
  output logic                  o_busy
);

  localparam logic [DATA_WIDTH-1:0] IDLE_WORD  = {LANES{IDLE_CODE}};
  localparam logic [DATA_WIDTH-1:0] START_WORD = {{(LANES-1){PREAMBLE_CODE}}, START_CODE};
  localparam logic [DATA_WIDTH-1:0] TERM_WORD  = {{(LANES-1){IDLE_CODE}}, TERM_CODE};
  localparam logic [LANES-1:0]      CTRL_ALL   = {LANES{1'b1}};
  localparam logic [LANES-1:0]      CTRL_START = {{(LANES-1){1'b0}}, 1'b1};

  state_t                state_r;
  mode_t                 mode_r;
  mode_t                 mode_sel_s;
  logic [LEN_WIDTH-1:0]  idle_cnt_r;
  logic [LEN_WIDTH-1:0]  data_cnt_r;
  logic [LEN_WIDTH-1:0]  len_r;
  logic [LEN_WIDTH-1:0]  eff_idle_s;
  logic [LEN_WIDTH-1:0]  eff_data_len_s;
  logic [7:0]            byte_base_r;
  logic [7:0]            byte_base_s;
  logic [31:0]           frame_cnt_r;
  logic [DATA_WIDTH-1:0] tx_data_r;
  logic [LANES-1:0]      tx_ctrl_r;
  logic                  busy_r;
  logic                  last_idle_s;
  logic                  last_data_s;
  logic                  prbs_load_s;
  logic                  prbs_adv_s;
  logic [DATA_WIDTH-1:0] prbs_word_s;
  logic [DATA_WIDTH-1:0] payload_s;

  // Zero lengths behave as one
  always_comb begin
    if (i_idle_len == {LEN_WIDTH{1'b0}}) begin
      eff_idle_s = LEN_WIDTH'(1);
    end else begin
      eff_idle_s = i_idle_len;
    end
    if (i_data_len == {LEN_WIDTH{1'b0}}) begin
      eff_data_len_s = LEN_WIDTH'(1);
    end else begin
      eff_data_len_s = i_data_len;
    end
  end

  assign last_idle_s = (idle_cnt_r >= (eff_idle_s - LEN_WIDTH'(1)));
  assign last_data_s = (data_cnt_r == (len_r - LEN_WIDTH'(1)));
  assign prbs_load_s = i_ready && (state_r == ST_START);
  assign prbs_adv_s  = i_ready && ((state_r == ST_START) ||
                                   ((state_r == ST_DATA) && !last_data_s));

  // The first payload word is built while START is accepted, before mode_r has been loaded
  always_comb begin
    if (state_r == ST_START) begin
      mode_sel_s  = mode_t'(i_mode);
      byte_base_s = 8'd0;
    end else begin
      mode_sel_s  = mode_r;
      byte_base_s = byte_base_r;
    end
  end

  // Payload word for the next DATA slot
  always_comb begin
    payload_s = {DATA_WIDTH{1'b0}};
    case (mode_sel_s)
      MODE_INCR: begin
        for (int i = 0; i < LANES; i++) begin
          payload_s[8*i +: 8] = byte_base_s + 8'(i);
        end
      end
      MODE_PRBS: payload_s = prbs_word_s;
      default:   payload_s = {LANES{8'hAA}};
    endcase
  end

  prbs31_gen #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_prbs (
    .clk       (clk),
    .i_rst     (i_rst),
    .i_load    (prbs_load_s),
    .i_advance (prbs_adv_s),
    .o_data    (prbs_word_s)
  );

  // Frame sequencer: state, counters and output word move only on accepted words
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_r     <= ST_IDLE;
      mode_r      <= MODE_FIXED;
      idle_cnt_r  <= {LEN_WIDTH{1'b0}};
      data_cnt_r  <= {LEN_WIDTH{1'b0}};
      len_r       <= LEN_WIDTH'(1);
      byte_base_r <= 8'd0;
      frame_cnt_r <= 32'd0;
      tx_data_r   <= IDLE_WORD;
      tx_ctrl_r   <= CTRL_ALL;
      busy_r      <= 1'b0;
    end else if (i_ready) begin
      case (state_r)
        ST_IDLE: begin
          if (last_idle_s && i_enable) begin
            state_r    <= ST_START;
            idle_cnt_r <= {LEN_WIDTH{1'b0}};
            tx_data_r  <= START_WORD;
            tx_ctrl_r  <= CTRL_START;
            busy_r     <= 1'b1;
          end else if (idle_cnt_r != {LEN_WIDTH{1'b1}}) begin
            idle_cnt_r <= idle_cnt_r + LEN_WIDTH'(1);
          end
        end
        ST_START: begin
          state_r     <= ST_DATA;
          len_r       <= eff_data_len_s;
          mode_r      <= mode_t'(i_mode);
          data_cnt_r  <= {LEN_WIDTH{1'b0}};
          byte_base_r <= 8'(LANES);
          tx_data_r   <= payload_s;
          tx_ctrl_r   <= {LANES{1'b0}};
        end
        ST_DATA: begin
          if (last_data_s) begin
            state_r   <= ST_TERM;
            tx_data_r <= TERM_WORD;
            tx_ctrl_r <= CTRL_ALL;
          end else begin
            data_cnt_r  <= data_cnt_r + LEN_WIDTH'(1);
            byte_base_r <= byte_base_r + 8'(LANES);
            tx_data_r   <= payload_s;
          end
        end
        ST_TERM: begin
          state_r     <= ST_IDLE;
          idle_cnt_r  <= {LEN_WIDTH{1'b0}};
          frame_cnt_r <= frame_cnt_r + 32'd1;
          tx_data_r   <= IDLE_WORD;
          tx_ctrl_r   <= CTRL_ALL;
          busy_r      <= 1'b0;
        end
        default: begin
          state_r   <= ST_IDLE;
          tx_data_r <= IDLE_WORD;
          tx_ctrl_r <= CTRL_ALL;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign o_tx_data   = tx_data_r;
  assign o_tx_ctrl   = tx_ctrl_r;
  assign o_frame_cnt = frame_cnt_r;
  assign o_busy      = busy_r;

endmodule

// File: tb/tb_mii_frame_gen.sv
// Directed self-checking bench for mii_frame_gen at DATA_WIDTH=64.
module tb_mii_frame_gen;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_enable;
  logic [15:0] i_idle_len;
  logic [15:0] i_data_len;
  logic [1:0]  i_mode;
  logic        i_ready;
  logic [63:0] o_tx_data;
  logic [7:0]  o_tx_ctrl;
  logic [31:0] o_frame_cnt;
  logic        o_busy;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
  localparam logic [63:0] START_W = 64'h55555555555555FB;
  localparam logic [63:0] TERM_W  = 64'h07070707070707FD;
  localparam logic [63:0] AA_W    = 64'hAAAAAAAAAAAAAAAA;
  localparam logic [63:0] INC0_W  = 64'h0706050403020100;
  localparam logic [63:0] INC1_W  = 64'h0F0E0D0C0B0A0908;
  localparam logic [63:0] INC2_W  = 64'h1716151413121110;
  localparam logic [63:0] PRBS0_W = 64'h3F00000070000000;
  localparam logic [7:0]  C_ALL   = 8'hFF;
  localparam logic [7:0]  C_START = 8'h01;
  localparam logic [7:0]  C_DATA  = 8'h00;

  // PRBS31 history: index j holds bit (j-31); the 31 bits before the first are the all-ones seed
  logic [31+3*64-1:0] hist;

  mii_frame_gen dut (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_enable    (i_enable),
    .i_idle_len  (i_idle_len),
    .i_data_len  (i_data_len),
    .i_mode      (i_mode),
    .i_ready     (i_ready),
    .o_tx_data   (o_tx_data),
    .o_tx_ctrl   (o_tx_ctrl),
    .o_frame_cnt (o_frame_cnt),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_prbs(input int w);
    return hist[31 + 64*w +: 64];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_word(input string tag, input logic [63:0] d, input logic [7:0] c,
                             input logic b);
    chk({tag, ".data"}, o_tx_data, d);
    chk({tag, ".ctrl"}, 64'(o_tx_ctrl), 64'(c));
    chk({tag, ".busy"}, 64'(o_busy), 64'(b));
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    hist = '0;
    for (int j = 0; j < 31; j++) hist[j] = 1'b1;
    for (int n = 0; n < 3*64; n++) hist[n+31] = hist[n] ^ hist[n+3];

    i_rst = 1'b1; i_enable = 1'b1; i_idle_len = 16'd2; i_data_len = 16'd3;
    i_mode = 2'd0; i_ready = 1'b1;
    repeat (2) tick();
    expect_word("reset", IDLE_W, C_ALL, 1'b0);
    chk("reset.cnt", 64'(o_frame_cnt), 64'd0);
    i_rst = 1'b0;

    // Fixed-pattern frame: 2 idle, start, 3 x AA, term
    expect_word("f1.idle0", IDLE_W, C_ALL, 1'b0); tick();
    expect_word("f1.idle1", IDLE_W, C_ALL, 1'b0); tick();
    expect_word("f1.start", START_W, C_START, 1'b1); tick();
    for (int k = 0; k < 3; k++) begin
      expect_word("f1.data", AA_W, C_DATA, 1'b1); tick();
    end
    expect_word("f1.term", TERM_W, C_ALL, 1'b1);
    chk("f1.cnt_before", 64'(o_frame_cnt), 64'd0);
    tick();
    chk("f1.cnt_after", 64'(o_frame_cnt), 64'd1);

    // Two incrementing frames of length 2, each restarting at byte 0
    i_mode = 2'd1; i_data_len = 16'd2;
    for (int f = 0; f < 2; f++) begin
      expect_word("inc.idle0", IDLE_W, C_ALL, 1'b0); tick();
      expect_word("inc.idle1", IDLE_W, C_ALL, 1'b0); tick();
      expect_word("inc.start", START_W, C_START, 1'b1); tick();
      expect_word("inc.w0", INC0_W, C_DATA, 1'b1); tick();
      expect_word("inc.w1", INC1_W, C_DATA, 1'b1); tick();
      expect_word("inc.term", TERM_W, C_ALL, 1'b1); tick();
    end
    chk("inc.cnt", 64'(o_frame_cnt), 64'd3);

    // Back-pressure: ready low for 3 cycles on the first payload word
    i_data_len = 16'd3;
    expect_word("bp.idle0", IDLE_W, C_ALL, 1'b0); tick();
    expect_word("bp.idle1", IDLE_W, C_ALL, 1'b0); tick();
    expect_word("bp.start", START_W, C_START, 1'b1); tick();
    expect_word("bp.w0", INC0_W, C_DATA, 1'b1);
    i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_word("bp.hold", INC0_W, C_DATA, 1'b1);
    end
    i_ready = 1'b1; tick();
    expect_word("bp.w1", INC1_W, C_DATA, 1'b1); tick();
    expect_word("bp.w2", INC2_W, C_DATA, 1'b1); tick();
    expect_word("bp.term", TERM_W, C_ALL, 1'b1); tick();
    chk("bp.cnt", 64'(o_frame_cnt), 64'd4);

    // PRBS frame; length and enable change mid-frame must not affect it
    i_mode = 2'd2;
    expect_word("p1.idle0", IDLE_W, C_ALL, 1'b0); tick();
    expect_word("p1.idle1", IDLE_W, C_ALL, 1'b0); tick();
    expect_word("p1.start", START_W, C_START, 1'b1); tick();
    chk("p1.w0_hand", o_tx_data, PRBS0_W);
    expect_word("p1.w0", ref_prbs(0), C_DATA, 1'b1);
    i_data_len = 16'd1; i_enable = 1'b0; tick();
    expect_word("p1.w1", ref_prbs(1), C_DATA, 1'b1); tick();
    expect_word("p1.w2", ref_prbs(2), C_DATA, 1'b1); tick();
    expect_word("p1.term", TERM_W, C_ALL, 1'b1); tick();
    chk("p1.cnt", 64'(o_frame_cnt), 64'd5);
    for (int k = 0; k < 4; k++) begin
      expect_word("p1.halt", IDLE_W, C_ALL, 1'b0); tick();
    end
    expect_word("p2.idle", IDLE_W, C_ALL, 1'b0);
    i_enable = 1'b1; i_data_len = 16'd3; tick();
    expect_word("p2.start", START_W, C_START, 1'b1); tick();
    for (int k = 0; k < 3; k++) begin
      expect_word("p2.w", ref_prbs(k), C_DATA, 1'b1); tick();
    end
    expect_word("p2.term", TERM_W, C_ALL, 1'b1); tick();
    chk("p2.cnt", 64'(o_frame_cnt), 64'd6);

    // Reset during the second payload word aborts without a TERM word
    i_mode = 2'd0;
    expect_word("rs.idle0", IDLE_W, C_ALL, 1'b0); tick();
    expect_word("rs.idle1", IDLE_W, C_ALL, 1'b0); tick();
    expect_word("rs.start", START_W, C_START, 1'b1); tick();
    expect_word("rs.w0", AA_W, C_DATA, 1'b1); tick();
    expect_word("rs.w1", AA_W, C_DATA, 1'b1);
    i_rst = 1'b1; tick();
    expect_word("rs.abort", IDLE_W, C_ALL, 1'b0);
    chk("rs.cnt", 64'(o_frame_cnt), 64'd0);
    i_rst = 1'b0; tick();
    expect_word("rs.idle_after", IDLE_W, C_ALL, 1'b0);
    chk("rs.cnt_after", 64'(o_frame_cnt), 64'd0);
    tick();
    expect_word("rs.restart", START_W, C_START, 1'b1);

    // Enable low from reset: idle only; then zero lengths act as one
    i_rst = 1'b1; i_enable = 1'b0; i_idle_len = 16'd0; i_data_len = 16'd0; i_mode = 2'd1;
    tick();
    i_rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      expect_word("en0.idle", IDLE_W, C_ALL, 1'b0);
      chk("en0.cnt", 64'(o_frame_cnt), 64'd0);
      if (k == 4) i_enable = 1'b1;
      tick();
    end
    expect_word("z.start", START_W, C_START, 1'b1); tick();
    expect_word("z.w0", INC0_W, C_DATA, 1'b1); tick();
    expect_word("z.term", TERM_W, C_ALL, 1'b1); tick();
    expect_word("z.idle", IDLE_W, C_ALL, 1'b0);
    chk("z.cnt", 64'(o_frame_cnt), 64'd1);
    tick();
    expect_word("z.start2", START_W, C_START, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
